fp_round_pack: RTL

//  Output stage of the FP32 multiplier datapath. Takes the unrounded product
//  (sign, 8-bit exponent, 26-bit mantissa with guard/sticky bits, special and

---
 rtl/fpu_pkg.sv | 34 +++
 rtl/fp_round_core.sv | 88 ++++++++
 rtl/fp_round_pack.sv | 80 ++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared FP32 constants, rounding-mode encodings, flag indices and the S1 beat record
// for the multiplier output stage.
package fpu_pkg;

  localparam int EXP_W  = 8;
  localparam int MANT_W = 26;
  localparam int FRAC_W = 23;

  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  localparam int FLG_NV = 4;
  localparam int FLG_DZ = 3;
  localparam int FLG_OF = 2;
  localparam int FLG_UF = 1;
  localparam int FLG_NX = 0;

  localparam logic [31:0] FP32_QNAN = 32'h7FC00000;
  localparam logic [30:0] FP32_MAXF = 31'h7F7FFFFF;
  localparam logic [30:0] FP32_INF  = 31'h7F800000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
    logic              invalid;
    logic              ovf;
    logic [2:0]        rm;
  } op_t;

endpackage

// File: rtl/fp_round_core.sv
// Combinational IEEE-754 rounding, overflow/underflow detection and FP32 packing.
// Flush-to-zero of tiny results is built in when FPU_ROUND_FTZ_EN is defined.
module fp_round_core
  import fpu_pkg::*;
#(
  parameter bit CANON_NAN = 1'b1
) (
  input  logic              sign,
  input  logic [EXP_W-1:0]  exp,
  input  logic [MANT_W-1:0] mant,
  input  logic              invalid,
  input  logic              ovf,
  input  logic [2:0]        rm,
  output logic [31:0]       result,
  output logic [4:0]        flags
);

  logic              lsb, g, s, nx, inc;
  logic [24:0]       sum;
  logic [EXP_W:0]    exp_r;
  logic [FRAC_W-1:0] frac;
  logic              of, tiny;

  always_comb begin
    lsb = mant[2];
    g   = mant[1];
    s   = mant[0];
    nx  = g | s;

    case (rm)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = nx & sign;
      RM_RUP:  inc = nx & ~sign;
      RM_RMM:  inc = g;
      default: inc = g & (s | lsb);
    endcase

    sum   = {1'b0, mant[25:2]} + {24'd0, inc};
    exp_r = {1'b0, exp} + {8'd0, sum[24]};
    // A subnormal that rounds up into the hidden bit becomes the smallest normal.
    if (exp == '0 && sum[23])
      exp_r = 9'd1;
    frac = sum[24] ? '0 : sum[22:0];

    of   = ovf || (exp_r >= 9'd255);
    tiny = (exp_r == '0) && (frac != '0);

    result = '0;
    flags  = '0;
    flags[FLG_DZ] = 1'b0;

    if (exp == 8'hFF) begin
      if (mant[24:2] != '0) begin
        result = CANON_NAN ? FP32_QNAN : {sign, 8'hFF, 1'b1, mant[23:2]};
        flags[FLG_NV] = invalid | ~mant[24];
      end else begin
        result = {sign, FP32_INF};
        flags[FLG_NV] = invalid;
      end
    end else if (invalid) begin
      result = FP32_QNAN;
      flags[FLG_NV] = 1'b1;
    end else if (of) begin
      case (rm)
        RM_RTZ:  result = {sign, FP32_MAXF};
        RM_RDN:  result = sign ? {1'b1, FP32_INF}  : {1'b0, FP32_MAXF};
        RM_RUP:  result = sign ? {1'b1, FP32_MAXF} : {1'b0, FP32_INF};
        default: result = {sign, FP32_INF};
      endcase
      flags[FLG_OF] = 1'b1;
      flags[FLG_NX] = 1'b1;
    end else if (tiny) begin
`ifdef FPU_ROUND_FTZ_EN
      result = {sign, 31'd0};
      flags[FLG_UF] = 1'b1;
      flags[FLG_NX] = 1'b1;
`else
      result = {sign, 8'd0, frac};
      flags[FLG_UF] = nx;
      flags[FLG_NX] = nx;
`endif
    end else begin
      result = {sign, exp_r[7:0], frac};
      flags[FLG_NX] = nx;
    end
  end

endmodule

// File: rtl/fp_round_pack.sv
// FP32 round/pack output stage: 2-cycle valid/ready pipeline, full backpressure, sticky fflags.
// Define FPU_ROUND_FTZ_EN to flush tiny results to signed zero.
module fp_round_pack
  import fpu_pkg::*;
#(
  parameter bit CANON_NAN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [7:0]  in_exp,
  input  logic [25:0] in_mant,
  input  logic        in_invalid,
  input  logic        in_ovf,
  input  logic [2:0]  in_rm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_flags,
  input  logic        flags_clr,
  output logic [4:0]  fflags
);

  op_t         s1;
  logic        s1_valid;
  logic        s2_adv;
  logic [31:0] core_result;
  logic [4:0]  core_flags;

  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid)
        s1 <= '{sign: in_sign, exp: in_exp, mant: in_mant,
                invalid: in_invalid, ovf: in_ovf, rm: in_rm};
    end
  end

  fp_round_core #(.CANON_NAN(CANON_NAN)) u_core (
    .sign    (s1.sign),
    .exp     (s1.exp),
    .mant    (s1.mant),
    .invalid (s1.invalid),
    .ovf     (s1.ovf),
    .rm      (s1.rm),
    .result  (core_result),
    .flags   (core_flags)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_flags  <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result <= core_result;
        out_flags  <= core_flags;
      end
    end
  end

  // A clear in the same cycle as a handshake keeps only the new flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      fflags <= '0;
    else
      fflags <= (flags_clr ? 5'd0 : fflags) | ((out_valid && out_ready) ? out_flags : 5'd0);
  end

endmodule
